// File: rtl/toggle_pkg.sv
// toggle_pkg: state encoding and default parameters shared by the toggle event receiver.
package toggle_pkg;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchronizer for a single asynchronous level, async active-high reset.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[STAGES-2:0], i_d};
    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/toggle_event_rx.sv
// toggle_event_rx: counts level changes on an async toggle line and offers batched counts over valid/ready.
module toggle_event_rx
    import toggle_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_in,
    output logic             ev_pulse,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic [CNT_W-1:0] cnt_data,
    output logic             cnt_ovf
);
    localparam logic [CNT_W-1:0] ACC_MAX = '1;
    logic w_sync, w_armed, w_ev, w_sat, w_load;
    logic r_prev, r_ev, r_acc_ovf, r_hold_ovf;
    logic [SYNC_STAGES:0] r_arm;
    logic [CNT_W-1:0] r_acc, r_hold;
    state_t r_state;
    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (t_in),
        .o_q (w_sync)
    );
    // Arm only once the reset-release level has reached t_prev, so it never reads as an event.
    assign w_armed = r_arm[SYNC_STAGES];
    assign w_ev    = w_armed & (w_sync ^ r_prev);
    assign w_sat   = r_acc == ACC_MAX;
    assign w_load  = (r_state == EMPTY || cnt_ready) && r_acc != '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev     <= 1'b0;
            r_arm      <= '0;
            r_ev       <= 1'b0;
            r_acc      <= '0;
            r_acc_ovf  <= 1'b0;
            r_hold     <= '0;
            r_hold_ovf <= 1'b0;
            r_state    <= EMPTY;
        end else begin
            r_prev <= w_sync;
            r_arm  <= {r_arm[SYNC_STAGES-1:0], 1'b1};
            r_ev   <= w_ev;
            if (w_load) begin
                r_state    <= FULL;
                r_hold     <= r_acc;
                r_hold_ovf <= r_acc_ovf;
                r_acc      <= CNT_W'(w_ev);
                r_acc_ovf  <= 1'b0;
            end else begin
                if (r_state == FULL && cnt_ready) begin
                    r_state    <= EMPTY;
                    r_hold     <= '0;
                    r_hold_ovf <= 1'b0;
                end
                if (w_ev) begin
                    r_acc     <= w_sat ? r_acc : r_acc + 1'b1;
                    r_acc_ovf <= r_acc_ovf | w_sat;
                end
            end
        end
    end
    assign ev_pulse  = r_ev;
    assign cnt_valid = r_state == FULL;
    assign cnt_data  = r_hold;
    assign cnt_ovf   = r_hold_ovf;
endmodule

// File: tb/tb_toggle_event_rx.sv
// tb_toggle_event_rx: directed and randomized checks of toggle_event_rx against an event-conservation model.
module tb_toggle_event_rx;
    logic clk, rst;
    logic t_in, ev_pulse, cnt_valid, cnt_ready, cnt_ovf;
    logic [7:0] cnt_data;
    logic t_in4, ev4, valid4, ready4, ovf4;
    logic [3:0] data4;
    int checks = 0;
    int errors = 0;
    int xfer_sum = 0;
    int ev_cnt = 0;
    int ovf_cnt = 0;

    toggle_event_rx #(.CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .t_in(t_in), .ev_pulse(ev_pulse), .cnt_valid(cnt_valid),
        .cnt_ready(cnt_ready), .cnt_data(cnt_data), .cnt_ovf(cnt_ovf)
    );
    toggle_event_rx #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst(rst), .t_in(t_in4), .ev_pulse(ev4), .cnt_valid(valid4),
        .cnt_ready(ready4), .cnt_data(data4), .cnt_ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe at negedge: valid&&ready here is exactly what the next posedge accepts.
    always @(negedge clk) begin
        if (cnt_valid === 1'b1 && cnt_ready === 1'b1) xfer_sum += int'(cnt_data);
        if (ev_pulse === 1'b1) ev_cnt++;
        if (cnt_valid === 1'b1 && cnt_ready === 1'b1 && cnt_ovf === 1'b1) ovf_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic level);
        #2 rst = 1'b1;
        t_in = level;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (cnt_valid !== 1'b0 || cnt_data !== 8'd0 || cnt_ovf !== 1'b0 || ev_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_state valid=%b data=%0d ovf=%b ev=%b, want 0 0 0 0", cnt_valid, cnt_data, cnt_ovf, ev_pulse);
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_no_event();
        int bad;
        #2 rst = 1'b1;
        t_in = 1'b1;
        cnt_ready = 1'b1;
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ev_pulse !== 1'b0 || cnt_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL no_event_after_release bad_cycles=%0d, want 0", bad);
        end
    endtask

    task automatic test_single();
        int base;
        do_reset(1'b0);
        cnt_ready = 1'b1;
        base = xfer_sum;
        t_in = 1'b1;
        tick();
        tick();
        checks++;
        if (ev_pulse !== 1'b0) begin
            errors++;
            $display("FAIL single_early ev=%b, want 0", ev_pulse);
        end
        tick();
        checks++;
        if (ev_pulse !== 1'b1 || cnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse ev=%b valid=%b, want 1 0", ev_pulse, cnt_valid);
        end
        tick();
        checks++;
        if (ev_pulse !== 1'b0 || cnt_valid !== 1'b1 || cnt_data !== 8'd1 || cnt_ovf !== 1'b0) begin
            errors++;
            $display("FAIL single_batch ev=%b valid=%b data=%0d ovf=%b, want 0 1 1 0", ev_pulse, cnt_valid, cnt_data, cnt_ovf);
        end
        tick();
        checks++;
        if (cnt_valid !== 1'b0 || cnt_data !== 8'd0 || xfer_sum - base != 1) begin
            errors++;
            $display("FAIL single_empty valid=%b data=%0d transferred=%0d, want 0 0 1", cnt_valid, cnt_data, xfer_sum - base);
        end
    endtask

    task automatic test_backpressure();
        int bad, base;
        cnt_ready = 1'b0;
        base = xfer_sum;
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            if (i % 4 == 0 && i < 20) t_in = ~t_in;
            tick();
            if (i >= 3 && (cnt_valid !== 1'b1 || cnt_data !== 8'd1)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable bad_cycles=%0d data=%0d, want 0 and 1", bad, cnt_data);
        end
        cnt_ready = 1'b1;
        tick();
        checks++;
        if (cnt_valid !== 1'b1 || cnt_data !== 8'd4 || xfer_sum - base != 1) begin
            errors++;
            $display("FAIL back_to_back valid=%b data=%0d transferred=%0d, want 1 4 1", cnt_valid, cnt_data, xfer_sum - base);
        end
        tick();
        checks++;
        if (cnt_valid !== 1'b0 || xfer_sum - base != 5) begin
            errors++;
            $display("FAIL backpressure_drain valid=%b transferred=%0d, want 0 5", cnt_valid, xfer_sum - base);
        end
    endtask

    task automatic test_coincident();
        int base;
        cnt_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        base = xfer_sum;
        t_in = ~t_in;
        tick();
        t_in = ~t_in;
        tick();
        tick();
        tick();
        checks++;
        if (cnt_valid !== 1'b1 || cnt_data !== 8'd1) begin
            errors++;
            $display("FAIL coincident_load valid=%b data=%0d, want 1 1", cnt_valid, cnt_data);
        end
        tick();
        checks++;
        if (cnt_valid !== 1'b1 || cnt_data !== 8'd1) begin
            errors++;
            $display("FAIL coincident_next valid=%b data=%0d, want 1 1", cnt_valid, cnt_data);
        end
        tick();
        checks++;
        if (cnt_valid !== 1'b0 || xfer_sum - base != 2) begin
            errors++;
            $display("FAIL coincident_total valid=%b transferred=%0d, want 0 2", cnt_valid, xfer_sum - base);
        end
    endtask

    task automatic test_saturate();
        ready4 = 1'b0;
        for (int i = 0; i < 84; i++) begin
            if (i % 4 == 0 && i < 80) t_in4 = ~t_in4;
            tick();
        end
        checks++;
        if (valid4 !== 1'b1 || data4 !== 4'd1 || ovf4 !== 1'b0) begin
            errors++;
            $display("FAIL sat_first valid=%b data=%0d ovf=%b, want 1 1 0", valid4, data4, ovf4);
        end
        ready4 = 1'b1;
        tick();
        checks++;
        if (valid4 !== 1'b1 || data4 !== 4'd15 || ovf4 !== 1'b1) begin
            errors++;
            $display("FAIL sat_batch valid=%b data=%0d ovf=%b, want 1 15 1", valid4, data4, ovf4);
        end
        tick();
        checks++;
        if (valid4 !== 1'b0 || data4 !== 4'd0 || ovf4 !== 1'b0) begin
            errors++;
            $display("FAIL sat_empty valid=%b data=%0d ovf=%b, want 0 0 0", valid4, data4, ovf4);
        end
    endtask

    task automatic test_random();
        int base_sum, base_ev, base_ovf, n_tog, gap;
        logic stall;
        logic [7:0] held;
        base_sum = xfer_sum;
        base_ev = ev_cnt;
        base_ovf = ovf_cnt;
        n_tog = 0;
        gap = 0;
        for (int i = 0; i < 1600; i++) begin
            if (gap == 0 && n_tog < 200) begin
                t_in = ~t_in;
                n_tog++;
                gap = $urandom_range(7, 3);
            end else if (gap > 0) gap--;
            cnt_ready = 1'($urandom_range(1, 0));
            stall = cnt_valid && !cnt_ready;
            held = cnt_data;
            tick();
            if (stall) begin
                checks++;
                if (cnt_valid !== 1'b1 || cnt_data !== held) begin
                    errors++;
                    $display("FAIL rand_stall cycle=%0d valid=%b data=%0d, want 1 %0d", i, cnt_valid, cnt_data, held);
                end
            end
        end
        cnt_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (xfer_sum - base_sum != n_tog) begin
            errors++;
            $display("FAIL rand_total transferred=%0d, want %0d", xfer_sum - base_sum, n_tog);
        end
        checks++;
        if (ev_cnt - base_ev != n_tog) begin
            errors++;
            $display("FAIL rand_pulses pulses=%0d, want %0d", ev_cnt - base_ev, n_tog);
        end
        checks++;
        if (ovf_cnt - base_ovf != 0 || cnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain ovf_batches=%0d valid=%b, want 0 0", ovf_cnt - base_ovf, cnt_valid);
        end
    endtask

    task automatic test_reset_mid();
        int base, bad;
        cnt_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i % 4 == 0 && i < 16) t_in = ~t_in;
            tick();
        end
        checks++;
        if (cnt_valid !== 1'b1 || cnt_data !== 8'd1) begin
            errors++;
            $display("FAIL mid_prefill valid=%b data=%0d, want 1 1", cnt_valid, cnt_data);
        end
        base = xfer_sum;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (cnt_valid !== 1'b0 || cnt_data !== 8'd0 || ev_pulse !== 1'b0 || cnt_ovf !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async valid=%b data=%0d ev=%b ovf=%b, want 0 0 0 0", cnt_valid, cnt_data, ev_pulse, cnt_ovf);
        end
        tick();
        tick();
        rst = 1'b0;
        cnt_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (cnt_valid !== 1'b0 || ev_pulse !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || xfer_sum != base) begin
            errors++;
            $display("FAIL mid_reset_discard bad_cycles=%0d transferred=%0d, want 0 0", bad, xfer_sum - base);
        end
    endtask

    initial begin
        rst = 1'b1;
        t_in = 1'b0;
        cnt_ready = 1'b0;
        t_in4 = 1'b0;
        ready4 = 1'b0;
        test_reset();
        test_no_event();
        test_single();
        test_backpressure();
        test_coincident();
        test_saturate();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
